// File: rtl/rename_undo_if.sv
// rename_undo_if: rename/commit/recover bus between pipeline (master) and rename_undo_unit (slave)
interface rename_undo_if #(
  parameter int PHYS_W = 6,
  parameter int CNT_W = 7
);
  logic alloc_valid;
  logic alloc_ready;
  logic alloc_uses_rd;
  logic [4:0] alloc_rd_arch;
  logic [PHYS_W-1:0] alloc_pd_new;
  logic [PHYS_W-1:0] alloc_pd_old;
  logic [4:0] rs1_arch;
  logic [4:0] rs2_arch;
  logic [PHYS_W-1:0] rs1_phys;
  logic [PHYS_W-1:0] rs2_phys;
  logic commit_valid;
  logic commit_uses_rd;
  logic [PHYS_W-1:0] commit_pd_old;
  logic recover_valid;
  logic recover_uses_rd;
  logic [4:0] recover_rd_arch;
  logic [PHYS_W-1:0] recover_pd_old;
  logic [PHYS_W-1:0] recover_pd_new;
  logic [CNT_W-1:0] free_count;
  logic err_double_free;
  modport master (
    output alloc_valid, alloc_uses_rd, alloc_rd_arch, rs1_arch, rs2_arch,
           commit_valid, commit_uses_rd, commit_pd_old,
           recover_valid, recover_uses_rd, recover_rd_arch, recover_pd_old, recover_pd_new,
    input  alloc_ready, alloc_pd_new, alloc_pd_old, rs1_phys, rs2_phys, free_count, err_double_free
  );
  modport slave (
    input  alloc_valid, alloc_uses_rd, alloc_rd_arch, rs1_arch, rs2_arch,
           commit_valid, commit_uses_rd, commit_pd_old,
           recover_valid, recover_uses_rd, recover_rd_arch, recover_pd_old, recover_pd_new,
    output alloc_ready, alloc_pd_new, alloc_pd_old, rs1_phys, rs2_phys, free_count, err_double_free
  );
endinterface

// File: rtl/rename_undo_unit.sv
// rename_undo_unit: speculative RAT + circular freelist with youngest-first undo walk; clk/rst (sync high), bus slave; optional RENAME_DOUBLE_FREE_CHK_EN
module rename_undo_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PHYS_W = $clog2(PHYS_REGS)
) (
  input logic clk,
  input logic rst,
  rename_undo_if.slave bus
);
  localparam int CNT_W = $clog2(PHYS_REGS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PHYS_REGS);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t state_q, state_d;
  logic [PHYS_W-1:0] rat_q [ARCH_REGS];
  logic [PHYS_W-1:0] rat_d [ARCH_REGS];
  logic [PHYS_W-1:0] fl_q [PHYS_REGS];
  logic [PHYS_W-1:0] fl_d [PHYS_REGS];
  logic [PHYS_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, cnt_pop;
  logic fire, c_req, r_req, c_ok, r_ok, dup_c, dup_r;
  function automatic logic [PHYS_W-1:0] inc(input logic [PHYS_W-1:0] p);
    return (p == PHYS_W'(PHYS_REGS - 1)) ? '0 : p + 1'b1;
  endfunction
  assign bus.alloc_ready = state_q == RUN && !bus.recover_valid &&
                           (!bus.alloc_uses_rd || bus.alloc_rd_arch == '0 || count_q != '0);
  assign fire = bus.alloc_valid && bus.alloc_ready && bus.alloc_uses_rd && bus.alloc_rd_arch != '0;
  assign bus.alloc_pd_new = bus.alloc_rd_arch == '0 ? '0 : fl_q[head_q];
  assign bus.alloc_pd_old = rat_q[bus.alloc_rd_arch];
  assign bus.rs1_phys = rat_q[bus.rs1_arch];
  assign bus.rs2_phys = rat_q[bus.rs2_arch];
  assign bus.free_count = count_q;
  assign c_req = bus.commit_valid && bus.commit_uses_rd;
  assign r_req = bus.recover_valid && bus.recover_uses_rd && bus.recover_rd_arch != '0;
  assign cnt_pop = count_q - CNT_W'(fire);
  // Pushes that would overfill the freelist are dropped; commit takes the slot before recover.
  assign c_ok = c_req && !dup_c && cnt_pop < FULL;
  assign r_ok = r_req && !dup_r && cnt_pop + CNT_W'(c_ok) < FULL;
  always_comb begin
    rat_d = rat_q;
    fl_d = fl_q;
    head_d = fire ? inc(head_q) : head_q;
    tail_d = tail_q;
    if (fire) rat_d[bus.alloc_rd_arch] = fl_q[head_q];
    if (r_req) rat_d[bus.recover_rd_arch] = bus.recover_pd_old;
    if (c_ok) fl_d[tail_q] = bus.commit_pd_old;
    if (r_ok) fl_d[c_ok ? inc(tail_q) : tail_q] = bus.recover_pd_new;
    if (c_ok) tail_d = inc(tail_d);
    if (r_ok) tail_d = inc(tail_d);
    count_d = cnt_pop + CNT_W'(c_ok) + CNT_W'(r_ok);
    state_d = bus.recover_valid ? RECOVER : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PHYS_W'(i);
      for (int i = 0; i < PHYS_REGS; i++) fl_q[i] <= i < PHYS_REGS - ARCH_REGS ? PHYS_W'(i + ARCH_REGS) : '0;
      head_q <= '0;
      tail_q <= PHYS_W'((PHYS_REGS - ARCH_REGS) % PHYS_REGS);
      count_q <= CNT_W'(PHYS_REGS - ARCH_REGS);
      state_q <= RUN;
    end else begin
      rat_q <= rat_d;
      fl_q <= fl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end
`ifdef RENAME_DOUBLE_FREE_CHK_EN
  logic [PHYS_REGS-1:0] infl_q, infl_d;
  logic err_q, err_d;
  // A tag still marked free (including one being popped this cycle) must not be pushed again.
  assign dup_c = c_req && infl_q[bus.commit_pd_old];
  assign dup_r = r_req && (infl_q[bus.recover_pd_new] || (c_req && bus.commit_pd_old == bus.recover_pd_new));
  assign err_d = err_q | dup_c | dup_r;
  always_comb begin
    infl_d = infl_q;
    if (fire) infl_d[fl_q[head_q]] = 1'b0;
    if (c_ok) infl_d[bus.commit_pd_old] = 1'b1;
    if (r_ok) infl_d[bus.recover_pd_new] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q <= {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
      err_q <= 1'b0;
    end else begin
      infl_q <= infl_d;
      err_q <= err_d;
    end
  end
  assign bus.err_double_free = err_q;
`else
  assign dup_c = 1'b0;
  assign dup_r = 1'b0;
  assign bus.err_double_free = 1'b0;
`endif
endmodule

// File: tb/tb_rename_undo_unit.sv
// tb_rename_undo_unit: directed self-checking bench for rename_undo_unit
module tb_rename_undo_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  rename_undo_if bus ();
  rename_undo_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.alloc_valid = 0; bus.alloc_uses_rd = 0; bus.alloc_rd_arch = 0;
    bus.rs1_arch = 0; bus.rs2_arch = 0;
    bus.commit_valid = 0; bus.commit_uses_rd = 0; bus.commit_pd_old = 0;
    bus.recover_valid = 0; bus.recover_uses_rd = 0; bus.recover_rd_arch = 0;
    bus.recover_pd_old = 0; bus.recover_pd_new = 0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    bus.rs1_arch = 5; bus.rs2_arch = 31; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 1;
    #1;
    checks++; if (bus.rs1_phys !== 6'd5) begin failures++; $display("FAIL reset_rs1 got=%0d exp=5", bus.rs1_phys); end
    checks++; if (bus.rs2_phys !== 6'd31) begin failures++; $display("FAIL reset_rs2 got=%0d exp=31", bus.rs2_phys); end
    checks++; if (bus.free_count !== 7'd32) begin failures++; $display("FAIL reset_free_count got=%0d exp=32", bus.free_count); end
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.alloc_ready); end
    checks++; if (bus.alloc_pd_new !== 6'd32) begin failures++; $display("FAIL reset_head got=%0d exp=32", bus.alloc_pd_new); end
    checks++; if (bus.err_double_free !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_double_free); end
  endtask

  task automatic test_rename;
    bus.alloc_valid = 1; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 1; bus.rs1_arch = 1;
    #1;
    checks++; if (bus.alloc_pd_new !== 6'd32) begin failures++; $display("FAIL ren1_new got=%0d exp=32", bus.alloc_pd_new); end
    checks++; if (bus.alloc_pd_old !== 6'd1) begin failures++; $display("FAIL ren1_old got=%0d exp=1", bus.alloc_pd_old); end
    checks++; if (bus.rs1_phys !== 6'd1) begin failures++; $display("FAIL ren1_nobypass got=%0d exp=1", bus.rs1_phys); end
    tick();
    bus.alloc_rd_arch = 2;
    #1;
    checks++; if (bus.alloc_pd_new !== 6'd33) begin failures++; $display("FAIL ren2_new got=%0d exp=33", bus.alloc_pd_new); end
    checks++; if (bus.alloc_pd_old !== 6'd2) begin failures++; $display("FAIL ren2_old got=%0d exp=2", bus.alloc_pd_old); end
    tick();
    bus.alloc_valid = 0; bus.rs1_arch = 1; bus.rs2_arch = 2;
    #1;
    checks++; if (bus.rs1_phys !== 6'd32) begin failures++; $display("FAIL ren_x1 got=%0d exp=32", bus.rs1_phys); end
    checks++; if (bus.rs2_phys !== 6'd33) begin failures++; $display("FAIL ren_x2 got=%0d exp=33", bus.rs2_phys); end
    checks++; if (bus.free_count !== 7'd30) begin failures++; $display("FAIL ren_count got=%0d exp=30", bus.free_count); end
  endtask

  task automatic test_x0;
    bus.alloc_valid = 1; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 0; bus.rs1_arch = 0;
    #1;
    checks++; if (bus.alloc_pd_new !== 6'd0) begin failures++; $display("FAIL x0_new got=%0d exp=0", bus.alloc_pd_new); end
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", bus.alloc_ready); end
    tick();
    bus.alloc_valid = 0;
    #1;
    checks++; if (bus.free_count !== 7'd30) begin failures++; $display("FAIL x0_count got=%0d exp=30", bus.free_count); end
    checks++; if (bus.rs1_phys !== 6'd0) begin failures++; $display("FAIL x0_rat got=%0d exp=0", bus.rs1_phys); end
  endtask

  task automatic test_recover;
    bus.alloc_valid = 1; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 3;
    #1;
    checks++; if (bus.alloc_pd_new !== 6'd34) begin failures++; $display("FAIL rec_ren3 got=%0d exp=34", bus.alloc_pd_new); end
    tick();
    bus.alloc_rd_arch = 4;
    #1;
    checks++; if (bus.alloc_pd_new !== 6'd35) begin failures++; $display("FAIL rec_ren4 got=%0d exp=35", bus.alloc_pd_new); end
    tick();
    bus.alloc_rd_arch = 5;
    bus.recover_valid = 1; bus.recover_uses_rd = 1; bus.recover_rd_arch = 4; bus.recover_pd_old = 4; bus.recover_pd_new = 35;
    #1;
    checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL rec_beat1_ready got=%b exp=0", bus.alloc_ready); end
    tick();
    bus.recover_rd_arch = 3; bus.recover_pd_old = 3; bus.recover_pd_new = 34;
    #1;
    checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL rec_beat2_ready got=%b exp=0", bus.alloc_ready); end
    tick();
    bus.recover_valid = 0; bus.rs1_arch = 3; bus.rs2_arch = 4;
    #1;
    checks++; if (bus.rs1_phys !== 6'd3) begin failures++; $display("FAIL rec_x3 got=%0d exp=3", bus.rs1_phys); end
    checks++; if (bus.rs2_phys !== 6'd4) begin failures++; $display("FAIL rec_x4 got=%0d exp=4", bus.rs2_phys); end
    checks++; if (bus.free_count !== 7'd30) begin failures++; $display("FAIL rec_count got=%0d exp=30", bus.free_count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL rec_exit_ready got=%b exp=0", bus.alloc_ready); end
    tick();
    bus.alloc_valid = 0;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL rec_run_ready got=%b exp=1", bus.alloc_ready); end
  endtask

  task automatic test_commit_recover;
    bus.alloc_valid = 1; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 5;
    #1;
    checks++; if (bus.alloc_pd_new !== 6'd36) begin failures++; $display("FAIL cr_ren5 got=%0d exp=36", bus.alloc_pd_new); end
    tick();
    bus.alloc_valid = 0;
    bus.commit_valid = 1; bus.commit_uses_rd = 1; bus.commit_pd_old = 1;
    bus.recover_valid = 1; bus.recover_uses_rd = 1; bus.recover_rd_arch = 5; bus.recover_pd_old = 5; bus.recover_pd_new = 36;
    tick();
    bus.commit_valid = 0; bus.recover_valid = 0; bus.rs1_arch = 5;
    #1;
    checks++; if (bus.free_count !== 7'd31) begin failures++; $display("FAIL cr_count got=%0d exp=31", bus.free_count); end
    checks++; if (bus.rs1_phys !== 6'd5) begin failures++; $display("FAIL cr_x5 got=%0d exp=5", bus.rs1_phys); end
    tick();
  endtask

  task automatic test_exhaust;
    logic [5:0] exp_tag [31];
    for (int i = 0; i < 27; i++) exp_tag[i] = 6'(37 + i);
    exp_tag[27] = 35; exp_tag[28] = 34; exp_tag[29] = 1; exp_tag[30] = 36;
    for (int i = 0; i < 31; i++) begin
      bus.alloc_valid = 1; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 5'(i % 31 + 1);
      #1;
      checks++; if (bus.alloc_pd_new !== exp_tag[i] || bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL exh_pop%0d got=%0d/%b exp=%0d/1", i, bus.alloc_pd_new, bus.alloc_ready, exp_tag[i]); end
      tick();
    end
    bus.alloc_rd_arch = 7;
    #1;
    checks++; if (bus.free_count !== 7'd0) begin failures++; $display("FAIL exh_count got=%0d exp=0", bus.free_count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL exh_ready_rd got=%b exp=0", bus.alloc_ready); end
    bus.alloc_uses_rd = 0;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL exh_ready_nord got=%b exp=1", bus.alloc_ready); end
    bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 0;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL exh_ready_x0 got=%b exp=1", bus.alloc_ready); end
    tick();
    bus.alloc_valid = 0;
    #1;
    checks++; if (bus.free_count !== 7'd0) begin failures++; $display("FAIL exh_count2 got=%0d exp=0", bus.free_count); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 30; i++) begin
      bus.commit_valid = 1; bus.commit_uses_rd = 1; bus.commit_pd_old = 6'(i + 1);
      bus.alloc_valid = i > 0; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 5'(i % 31 + 1);
      #1;
      if (i > 0) begin
        checks++; if (bus.alloc_pd_new !== 6'(i) || bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL b2b_pop%0d got=%0d/%b exp=%0d/1", i, bus.alloc_pd_new, bus.alloc_ready, i); end
      end
      tick();
    end
    bus.commit_valid = 0; bus.alloc_valid = 0; bus.alloc_rd_arch = 9;
    #1;
    checks++; if (bus.free_count !== 7'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", bus.free_count); end
    checks++; if (bus.alloc_pd_new !== 6'd30) begin failures++; $display("FAIL b2b_head got=%0d exp=30", bus.alloc_pd_new); end
  endtask

  task automatic test_rst_mid_recover;
    do_reset();
    bus.recover_valid = 1; bus.recover_uses_rd = 1; bus.recover_rd_arch = 9; bus.recover_pd_old = 50; bus.recover_pd_new = 9;
    bus.rs1_arch = 9;
    tick();
    checks++; if (bus.rs1_phys !== 6'd50) begin failures++; $display("FAIL rmr_undo got=%0d exp=50", bus.rs1_phys); end
    rst = 1; bus.commit_valid = 1; bus.commit_uses_rd = 1; bus.commit_pd_old = 3;
    tick();
    rst = 0; bus.recover_valid = 0; bus.commit_valid = 0; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 1;
    #1;
    checks++; if (bus.rs1_phys !== 6'd9) begin failures++; $display("FAIL rmr_rat got=%0d exp=9", bus.rs1_phys); end
    checks++; if (bus.free_count !== 7'd32) begin failures++; $display("FAIL rmr_count got=%0d exp=32", bus.free_count); end
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL rmr_ready got=%b exp=1", bus.alloc_ready); end
    checks++; if (bus.alloc_pd_new !== 6'd32) begin failures++; $display("FAIL rmr_head got=%0d exp=32", bus.alloc_pd_new); end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 37; i++) begin
      bus.commit_valid = 1; bus.commit_uses_rd = 1; bus.commit_pd_old = 6'(i % 32);
      tick();
    end
    bus.commit_valid = 0; bus.alloc_uses_rd = 1; bus.alloc_rd_arch = 2;
    #1;
    checks++; if (bus.free_count !== 7'd64) begin failures++; $display("FAIL ovf_count got=%0d exp=64", bus.free_count); end
    checks++; if (bus.alloc_pd_new !== 6'd32) begin failures++; $display("FAIL ovf_head got=%0d exp=32", bus.alloc_pd_new); end
  endtask

`ifdef RENAME_DOUBLE_FREE_CHK_EN
  task automatic test_double_free;
    do_reset();
    bus.commit_valid = 1; bus.commit_uses_rd = 1; bus.commit_pd_old = 40;
    tick();
    bus.commit_valid = 0;
    #1;
    checks++; if (bus.err_double_free !== 1'b1) begin failures++; $display("FAIL dbl_err got=%b exp=1", bus.err_double_free); end
    checks++; if (bus.free_count !== 7'd32) begin failures++; $display("FAIL dbl_count got=%0d exp=32", bus.free_count); end
    bus.commit_valid = 1; bus.commit_pd_old = 5;
    tick();
    bus.commit_valid = 0;
    #1;
    checks++; if (bus.err_double_free !== 1'b1 || bus.free_count !== 7'd33) begin failures++; $display("FAIL dbl_sticky got=%b/%0d exp=1/33", bus.err_double_free, bus.free_count); end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_rename();
    test_x0();
    test_recover();
    test_commit_recover();
    test_exhaust();
    test_back_to_back();
    test_rst_mid_recover();
    test_overflow();
`ifdef RENAME_DOUBLE_FREE_CHK_EN
    test_double_free();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
